// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/reset sequencer for a 3-digit BCD stopwatch (0:00-9:59).
// Latency: button, tick and reset effects appear on all outputs one cycle later.
// No backpressure; optional blinking digits while paused when STOPWATCH_BLINK_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        btn_start_stop_i,
  input  logic        btn_lap_reset_i,
  output logic [11:0] number_o,
  output logic [2:0]  digit_en_o,
  output logic        running_o,
  output logic        ovf_o
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    m1_q, m1_d;
  logic [3:0]    s10_q, s10_d;
  logic [3:0]    s1_q, s1_d;
  logic [11:0]   lap_q, lap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_q, ovf_d;
  logic [11:0]   number_q, number_d;
  logic          running_q, running_d;

  logic          clear_time;
  logic          capture_lap;
  logic          count_en;

  // Next-state logic; start/stop has priority over lap/reset in the same cycle.
  always_comb begin
    state_d     = state_q;
    clear_time  = 1'b0;
    capture_lap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_start_stop_i) begin
          state_d = S_RUN;
        end else if (btn_lap_reset_i) begin
          clear_time = 1'b1;
        end
      end
      S_RUN: begin
        if (btn_start_stop_i) begin
          state_d = S_PAUSE;
        end else if (btn_lap_reset_i) begin
          state_d     = S_LAP;
          capture_lap = 1'b1;
        end
      end
      S_LAP: begin
        if (btn_start_stop_i) begin
          state_d = S_PAUSE;
        end else if (btn_lap_reset_i) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (btn_start_stop_i) begin
          state_d = S_RUN;
        end else if (btn_lap_reset_i) begin
          state_d    = S_IDLE;
          clear_time = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counting is qualified by the current state, so a tick in the cycle that
  // leaves RUN/LAP still counts and one in the cycle that enters RUN does not.
  assign count_en = tick_i && ((state_q == S_RUN) || (state_q == S_LAP));

  // Prescaler, BCD time, lap capture and sticky overflow.
  always_comb begin
    presc_d = presc_q;
    m1_d    = m1_q;
    s10_d   = s10_q;
    s1_d    = s1_q;
    ovf_d   = ovf_q;
    lap_d   = lap_q;
    if (capture_lap) begin
      // Pre-increment time is captured even if a rollover happens this cycle.
      lap_d = {m1_q, s10_q, s1_q};
    end
    if (clear_time) begin
      presc_d = '0;
      m1_d    = 4'd0;
      s10_d   = 4'd0;
      s1_d    = 4'd0;
      ovf_d   = 1'b0;
    end else if (count_en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (s1_q >= 4'd9) begin
          s1_d = 4'd0;
          if (s10_q >= 4'd5) begin
            s10_d = 4'd0;
            if (m1_q >= 4'd9) begin
              m1_d  = 4'd0;
              ovf_d = 1'b1;
            end else begin
              m1_d = m1_q + 4'd1;
            end
          end else begin
            s10_d = s10_q + 4'd1;
          end
        end else begin
          s1_d = s1_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Registered outputs follow the next state so they change with it.
  always_comb begin
    number_d  = (state_d == S_LAP) ? lap_d : {m1_d, s10_d, s1_d};
    running_d = (state_d == S_RUN) || (state_d == S_LAP);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      m1_q      <= 4'd0;
      s10_q     <= 4'd0;
      s1_q      <= 4'd0;
      lap_q     <= 12'h000;
      presc_q   <= '0;
      ovf_q     <= 1'b0;
      number_q  <= 12'h000;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m1_q      <= m1_d;
      s10_q     <= s10_d;
      s1_q      <= s1_d;
      lap_q     <= lap_d;
      presc_q   <= presc_d;
      ovf_q     <= ovf_d;
      number_q  <= number_d;
      running_q <= running_d;
    end
  end

  assign number_o  = number_q;
  assign running_o = running_q;
  assign ovf_o     = ovf_q;

`ifdef STOPWATCH_BLINK_EN
  logic [PW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Free-running blink divider, advanced by every tick regardless of state.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick_i) begin
      if (blink_cnt_q == PRESC_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink divider registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Digits blank on the odd blink phase only while paused.
  always_comb begin
    digit_en_o = ((state_q == S_PAUSE) && blink_phase_q) ? 3'b000 : 3'b111;
  end
`else
  assign digit_en_o = 3'b111;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl with TICK_DIV = 4.
// Ticks are issued on every third clock; outputs are sampled 1 ns after the rising edge.
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        ss;
  logic        lr;
  logic [11:0] number;
  logic [2:0]  digit_en;
  logic        running;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int ticks_seen = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .tick_i           (tick),
    .btn_start_stop_i (ss),
    .btn_lap_reset_i  (lr),
    .number_o         (number),
    .digit_en_o       (digit_en),
    .running_o        (running),
    .ovf_o            (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic cyc(input logic t, input logic s, input logic l);
    tick = t;
    ss   = s;
    lr   = l;
    @(posedge clk);
    #1;
    if (rst) ticks_seen = 0;
    else if (t) ticks_seen++;
    tick = 1'b0;
    ss   = 1'b0;
    lr   = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    total++; if (number !== 12'h000) begin bad++; $display("FAIL reset_number got=%h want=000", number); end
    total++; if (digit_en !== 3'b111) begin bad++; $display("FAIL reset_digit_en got=%b want=111", digit_en); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_run();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_start_running got=%b want=1", running); end
    tick_n(39);
    total++; if (number !== 12'h009) begin bad++; $display("FAIL run_39_ticks got=%h want=009", number); end
    tick_n(1);
    total++; if (number !== 12'h010) begin bad++; $display("FAIL run_40_ticks got=%h want=010", number); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_40_running got=%b want=1", running); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL run_40_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_rollover();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(236);
    total++; if (number !== 12'h059) begin bad++; $display("FAIL roll_059 got=%h want=059", number); end
    tick_n(3);
    total++; if (number !== 12'h059) begin bad++; $display("FAIL roll_059_hold got=%h want=059", number); end
    tick_n(1);
    total++; if (number !== 12'h100) begin bad++; $display("FAIL roll_100 got=%h want=100", number); end
    tick_n(2156);
    total++; if (number !== 12'h959) begin bad++; $display("FAIL roll_959 got=%h want=959", number); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL roll_959_ovf got=%b want=0", ovf); end
    tick_n(4);
    total++; if (number !== 12'h000) begin bad++; $display("FAIL roll_wrap got=%h want=000", number); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL roll_wrap_ovf got=%b want=1", ovf); end
    tick_n(10);
    total++; if (number !== 12'h002) begin bad++; $display("FAIL roll_after_wrap got=%h want=002", number); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL roll_ovf_sticky got=%b want=1", ovf); end
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL roll_pause_running got=%b want=0", running); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL roll_pause_ovf got=%b want=1", ovf); end
    cyc(1'b0, 1'b0, 1'b1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL roll_clear_ovf got=%b want=0", ovf); end
    total++; if (number !== 12'h000) begin bad++; $display("FAIL roll_clear_number got=%h want=000", number); end
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(3);
    total++; if (number !== 12'h000) begin bad++; $display("FAIL roll_presc_cleared got=%h want=000", number); end
    tick_n(1);
    total++; if (number !== 12'h001) begin bad++; $display("FAIL roll_after_clear got=%h want=001", number); end
  endtask

  task automatic test_lap();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(48);
    total++; if (number !== 12'h012) begin bad++; $display("FAIL lap_pre got=%h want=012", number); end
    cyc(1'b0, 1'b0, 1'b1);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL lap_running got=%b want=1", running); end
    tick_n(20);
    total++; if (number !== 12'h012) begin bad++; $display("FAIL lap_frozen got=%h want=012", number); end
    cyc(1'b0, 1'b0, 1'b1);
    total++; if (number !== 12'h017) begin bad++; $display("FAIL lap_release got=%h want=017", number); end
    tick_n(3);
    cyc(1'b1, 1'b0, 1'b1);
    total++; if (number !== 12'h017) begin bad++; $display("FAIL lap_capture_pre_inc got=%h want=017", number); end
    cyc(1'b0, 1'b0, 1'b1);
    total++; if (number !== 12'h018) begin bad++; $display("FAIL lap_live_after got=%h want=018", number); end
    cyc(1'b0, 1'b0, 1'b1);
    tick_n(4);
    total++; if (number !== 12'h018) begin bad++; $display("FAIL lap_frozen2 got=%h want=018", number); end
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (number !== 12'h019) begin bad++; $display("FAIL lap_to_pause_number got=%h want=019", number); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL lap_to_pause_running got=%b want=0", running); end
  endtask

  task automatic test_pause();
    logic [2:0] exp_en;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(6);
    total++; if (number !== 12'h001) begin bad++; $display("FAIL pause_pre got=%h want=001", number); end
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
`ifdef STOPWATCH_BLINK_EN
      exp_en = (((ticks_seen / 4) % 2) != 0) ? 3'b000 : 3'b111;
`else
      exp_en = 3'b111;
`endif
      total++; if (digit_en !== exp_en) begin bad++; $display("FAIL pause_digit_en tick=%0d got=%b want=%b", ticks_seen, digit_en, exp_en); end
    end
    total++; if (number !== 12'h001) begin bad++; $display("FAIL pause_hold got=%h want=001", number); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b want=0", running); end
    cyc(1'b0, 1'b1, 1'b0);
    total++; if (digit_en !== 3'b111) begin bad++; $display("FAIL resume_digit_en got=%b want=111", digit_en); end
    tick_n(1);
    total++; if (number !== 12'h001) begin bad++; $display("FAIL resume_tick1 got=%h want=001", number); end
    tick_n(1);
    total++; if (number !== 12'h002) begin bad++; $display("FAIL resume_tick2 got=%h want=002", number); end
  endtask

  task automatic test_btn_tick_edge();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(3);
    cyc(1'b1, 1'b1, 1'b0);
    total++; if (number !== 12'h001) begin bad++; $display("FAIL edge_stop_tick_counted got=%h want=001", number); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL edge_stop_running got=%b want=0", running); end
    tick_n(2);
    cyc(1'b1, 1'b1, 1'b0);
    tick_n(3);
    total++; if (number !== 12'h001) begin bad++; $display("FAIL edge_start_tick_ignored got=%h want=001", number); end
    tick_n(1);
    total++; if (number !== 12'h002) begin bad++; $display("FAIL edge_after_start got=%h want=002", number); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    tick_n(4);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    tick_n(8);
    total++; if (number !== 12'h003) begin bad++; $display("FAIL both_pre got=%h want=003", number); end
    cyc(1'b0, 1'b1, 1'b1);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL both_running got=%b want=0", running); end
    total++; if (number !== 12'h003) begin bad++; $display("FAIL both_number got=%h want=003", number); end
    total++; if (dut.lap_q !== 12'h001) begin bad++; $display("FAIL both_lap_unchanged got=%h want=001", dut.lap_q); end
    tick_n(4);
    total++; if (number !== 12'h003) begin bad++; $display("FAIL both_paused_hold got=%h want=003", number); end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    tick_n(4);
    total++; if (number !== 12'h003) begin bad++; $display("FAIL rst_lap_frozen got=%h want=003", number); end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    total++; if (number !== 12'h000) begin bad++; $display("FAIL rst_lap_number got=%h want=000", number); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_lap_running got=%b want=0", running); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_lap_ovf got=%b want=0", ovf); end
    total++; if (digit_en !== 3'b111) begin bad++; $display("FAIL rst_lap_digit_en got=%b want=111", digit_en); end
    tick_n(4);
    total++; if (number !== 12'h000) begin bad++; $display("FAIL idle_ignores_tick got=%h want=000", number); end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    ss   = 1'b0;
    lr   = 1'b0;
    test_reset();
    test_run();
    test_rollover();
    test_lap();
    test_pause();
    test_btn_tick_edge();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap/reset controller for the stopwatch datapath. Takes the one-cycle tick enable from the clock divider and two debounced button pulses, sequences the three-digit BCD time (minutes_1, seconds_10, seconds_1, range 0:00–9:59), and drives the 12-bit `number` bus and digit-enable mask consumed by the multiplexed 7-segment display driver. Sits between `clkDivider` and `Display_Digits` in the top level.

## Interface
- `TICK_DIV`, 100: tick pulses per second; legal 2..65535.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle enable pulse from the clock divider.
- `btn_start_stop`  in  1  one-cycle debounced pulse.
- `btn_lap_reset`  in  1  one-cycle debounced pulse.
- `number`  out  12  displayed time {minutes_1, seconds_10, seconds_1}, BCD, registered.
- `digit_en`  out  3  per-digit display enable, bit 0 = seconds_1.
- `running`  out  1  high in RUNNING and LAP.
- `ovf`  out  1  sticky: time has wrapped 9:59 -> 0:00.

## Operation
- Single clock, single synchronous, active-high reset. All state is updated only on the `clk` edge.
- Internal state:
  - live time register, 3 BCD digits;
  - lap register, 12 bits;
  - prescaler `presc`, `$clog2(TICK_DIV)` bits;
  - FSM.
- FSM states:
  - IDLE. `btn_start_stop` -> RUNNING. `btn_lap_reset` -> IDLE; clears time, `presc` and `ovf`.
  - RUNNING. `btn_start_stop` -> PAUSED. `btn_lap_reset` -> LAP; copies the live time into the lap register.
  - LAP. Counting continues and the display is frozen on the lap register. `btn_lap_reset` -> RUNNING. `btn_start_stop` -> PAUSED.
  - PAUSED. `btn_start_stop` -> RUNNING. `btn_lap_reset` -> IDLE; clears time, `presc` and `ovf`.
- Both buttons in the same cycle: `btn_start_stop` wins and `btn_lap_reset` is dropped.
- Counting, evaluated on the current state:
  - In RUNNING or LAP, each `tick` increments `presc`.
  - At `presc == TICK_DIV-1` with `tick`, `presc` wraps to 0 and the time increments by one second.
  - Digit carries: seconds_1 9->0 carries into seconds_10; seconds_10 5->0 carries into minutes_1; minutes_1 9->0 sets `ovf`.
  - Digits never hold values outside 0..9 (seconds_10 0..5).
- `presc` holds its value in PAUSED, so sub-second progress is preserved across a pause. It is cleared only in IDLE and on reset.
- `number` shows the lap register in LAP and the live time in every other state.

## Timing
- Reset values: state IDLE, time 0:00, lap 0, `presc` 0, `number` 12'h000, `digit_en` 3'b111, `running` 0, `ovf` 0.
- Button pulse in cycle N: state, `running` and `number` source change in cycle N+1.
- `tick` in the same cycle as a `btn_start_stop` that leaves RUNNING or LAP is counted. `tick` in the same cycle as a `btn_start_stop` that leaves PAUSED or IDLE is not counted.
- Second rollover caused by `tick` in cycle N: new time appears on `number` in cycle N+1.
- LAP entry in cycle N with a rollover in the same cycle: the lap register captures the pre-increment time.
- `rst` mid-operation overrides all inputs that cycle; all outputs take their reset values at N+1.
- `tick` is ignored in IDLE and PAUSED (except by the blink counter when enabled).

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - Adds a free-running blink counter, same width as `presc`, clocked by `tick` in every state and reset to 0.
  - `blink_phase` toggles each time that counter wraps at `TICK_DIV-1`; reset value 0.
  - In PAUSED, `digit_en` = 3'b111 when `blink_phase` = 0 and 3'b000 when `blink_phase` = 1.
  - In all other states, `digit_en` = 3'b111.
- Not defined: no blink counter is built, and `digit_en` is constant 3'b111.
- `number` is identical in both builds.

## Test plan
All scenarios use `TICK_DIV` = 4, with `tick` pulsed every 3rd clock.
- Reset, `btn_start_stop`, then 40 ticks -> `number` = 12'h010, `running` = 1, `ovf` = 0.
- Run to 12'h059, then 4 more ticks -> 12'h100. Preload to 9:59, then 4 more ticks -> 12'h000 and `ovf` = 1. `ovf` stays 1 until `btn_lap_reset` from PAUSED.
- Run to 12'h012, `btn_lap_reset`, 20 more ticks -> `number` = 12'h012 while internal time reaches 12'h017. A second `btn_lap_reset` -> `number` = 12'h017 on the next cycle.
- Pause after 6 ticks (`presc` = 2), wait 50 ticks, resume, then 2 more ticks -> `number` = 12'h002 exactly at the 2nd tick.
- Both buttons in the same cycle from RUNNING -> PAUSED with the lap register unchanged. `rst` asserted in LAP -> all outputs at reset values in the next cycle.
- With `STOPWATCH_BLINK_EN`, in PAUSED -> `digit_en` alternates 111/000 every 4 ticks. Without the macro -> `digit_en` is constant 111.
